// File: rtl/alu_pkg.sv
// Shared definitions for the CPU ALU and the shift-and-add multiply sequencer:
// ALU opcodes and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier (low WIDTH bits of the product) that borrows
// the shared datapath ALU for its add and left-shift steps while busy.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  mul_state_t       state, state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [5:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (EARLY_EXIT && (op_b == '0)) state_next = DONE;
          else                            state_next = ADD;
        end
      end
      ADD:   state_next = SHIFT;
      SHIFT: begin
        if ((cnt == LAST_CNT) || (EARLY_EXIT && ((mplier >> 1) == '0)))
          state_next = DONE;
        else
          state_next = ADD;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU is driven in every state so it never sees an undefined opcode.
  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = ALU_ADD;
    busy     = (state != IDLE);
    done     = (state == DONE);
    unique case (state)
      ADD: begin
        alu_srca = acc;
        alu_srcb = mcand;
        alu_ctrl = ALU_ADD;
      end
      SHIFT: begin
        alu_srca = WIDTH'(1);
        alu_srcb = mcand;
        alu_ctrl = ALU_SLL;
      end
      default: begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_ctrl = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= '0;
            // acc still holds the previous result here, so a zero multiplier
            // publishes the cleared value directly.
            if (state_next == DONE) product <= '0;
          end
        end
        ADD: begin
          if (mplier[0]) acc <= alu_result;
        end
        SHIFT: begin
          mcand  <= alu_result;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (state_next == DONE) product <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: two instances (early exit on/off), each
// wired to its own behavioural copy of the shared ALU.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [31:0] op_a, op_b;
  logic [31:0] srca0, srcb0, res0, prod0;
  logic [31:0] srca1, srcb1, res1, prod1;
  logic [2:0]  ctrl0, ctrl1;
  logic        busy0, done0, busy1, done1;

  int checks = 0;
  int errors = 0;
  int dcnt1  = 0;

  typedef struct {
    logic [31:0] prod;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(op_a), .op_b(op_b),
    .alu_srca(srca0), .alu_srcb(srcb0), .alu_ctrl(ctrl0), .alu_result(res0),
    .busy(busy0), .done(done0), .product(prod0)
  );

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a), .op_b(op_b),
    .alu_srca(srca1), .alu_srcb(srcb1), .alu_ctrl(ctrl1), .alu_result(res1),
    .busy(busy1), .done(done1), .product(prod1)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_OR:  return a | b;
      ALU_SLL: return b << a[4:0];
      default: return 32'h0;
    endcase
  endfunction

  always_comb res0 = alu_f(srca0, srcb0, ctrl0);
  always_comb res1 = alu_f(srca1, srcb1, ctrl1);

  always @(posedge clk) if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;

  function automatic int exp_lat(input bit ee, input logic [31:0] b);
    int k = -1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    if (!ee) return 65;
    if (k < 0) return 1;
    return 1 + 2 * (k + 1);
  endfunction

  function automatic logic get_done(input bit s);
    return s ? done1 : done0;
  endfunction
  function automatic logic get_busy(input bit s);
    return s ? busy1 : busy0;
  endfunction
  function automatic logic [31:0] get_prod(input bit s);
    return s ? prod1 : prod0;
  endfunction
  function automatic logic [2:0] get_ctrl(input bit s);
    return s ? ctrl1 : ctrl0;
  endfunction

  task automatic run_mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         input string name);
    exp_t e;
    int   n;
    bit   busy_ok, ctrl_ok;
    @(negedge clk);
    op_a = a;
    op_b = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    sb.push_back('{a * b, exp_lat(sel, b)});
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    n = 1;
    busy_ok = 1'b1;
    ctrl_ok = 1'b1;
    while (get_done(sel) !== 1'b1 && n < 200) begin
      if (get_busy(sel) !== 1'b1) busy_ok = 1'b0;
      if (get_ctrl(sel) !== ALU_ADD && get_ctrl(sel) !== ALU_SLL) ctrl_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (get_done(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, get_done(sel), n);
    end
    checks++;
    if (n !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
    end
    checks++;
    if (get_prod(sel) !== e.prod) begin
      errors++;
      $display("FAIL %s product: got %h required %h", name, get_prod(sel), e.prod);
    end
    checks++;
    if (!busy_ok || !ctrl_ok || get_busy(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s busy/ctrl span: busy_ok=%b ctrl_ok=%b busy_at_done=%b required 1 1 1",
               name, busy_ok, ctrl_ok, get_busy(sel));
    end
    @(posedge clk); #1;
    checks++;
    if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, get_done(sel), get_busy(sel));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || prod1 !== 32'h0 ||
        busy0 !== 1'b0 || done0 !== 1'b0 || prod0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b/%b done=%b/%b product=%h/%h required 0 0 0",
               busy0, busy1, done0, done1, prod0, prod1);
    end
    checks++;
    if (srca1 !== 32'h0 || srcb1 !== 32'h0 || ctrl1 !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu: srca=%h srcb=%h ctrl=%b required 0 0 000", srca1, srcb1, ctrl1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_mul(1'b1, 32'd3, 32'd5, "basic_3x5");
    run_mul(1'b1, 32'd1, 32'h8000_0000, "msb_only");
  endtask

  task automatic test_zero();
    run_mul(1'b1, 32'h1234, 32'h0, "zero_mplier");
  endtask

  task automatic test_full();
    run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "full_wrap");
    run_mul(1'b0, 32'hDEAD_BEEF, 32'h1, "no_early_exit");
    run_mul(1'b0, 32'h1234, 32'h0, "no_early_exit_zero");
  endtask

  task automatic test_busy_ignore();
    int n, d0;
    d0 = dcnt1;
    @(negedge clk);
    op_a = 32'd7;
    op_b = 32'd9;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 1;
    while (done1 !== 1'b1 && n < 200) begin
      if (n == 3) begin
        op_a = 32'd2;
        op_b = 32'd2;
        start1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start1 = 1'b0;
    checks++;
    if (n !== 9 || prod1 !== 32'd63) begin
      errors++;
      $display("FAIL busy_ignore: latency=%0d product=%0d required 9 63", n, prod1);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (dcnt1 - d0 !== 1) begin
      errors++;
      $display("FAIL busy_ignore_pulses: got %0d required 1", dcnt1 - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = dcnt1;
    @(negedge clk);
    op_a = 32'd6;
    op_b = 32'hFF;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || prod1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h required 0 0 0", busy1, done1, prod1);
    end
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (dcnt1 !== d0) begin
      errors++;
      $display("FAIL reset_mid_no_done: pulses=%0d required 0", dcnt1 - d0);
    end
    run_mul(1'b1, 32'd4, 32'd4, "after_reset_4x4");
  endtask

  task automatic test_back_to_back();
    run_mul(1'b1, 32'd10, 32'd11, "b2b_first");
    run_mul(1'b1, 32'hFFFF_0001, 32'h0001_0003, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ((i % 97) == 0) b = 32'h0;
      run_mul(1'b1, a, b, "random");
    end
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a   = 32'h0;
    op_b   = 32'h0;
    test_reset();
    test_basic();
    test_zero();
    test_full();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
